// File: rtl/truth_table_extractor_if.sv
// Control/status and gate-under-test bus of truth_table_extractor.
// glitch_seen exists only when TT_EXTRACT_VOTE_EN is defined.
interface truth_table_extractor_if #(
    parameter int SETTLE_W = 8
);
    logic                start;
    logic [SETTLE_W-1:0] settle_cycles;
    logic [7:0]          expected;
    logic [2:0]          dut_in;
    logic                dut_out;
    logic                busy;
    logic                done;
    logic [7:0]          table_out;
    logic                match;
`ifdef TT_EXTRACT_VOTE_EN
    logic                glitch_seen;

    modport master (
        output start, settle_cycles, expected, dut_out,
        input  dut_in, busy, done, table_out, match, glitch_seen
    );
    modport slave (
        input  start, settle_cycles, expected, dut_out,
        output dut_in, busy, done, table_out, match, glitch_seen
    );
`else
    modport master (
        output start, settle_cycles, expected, dut_out,
        input  dut_in, busy, done, table_out, match
    );
    modport slave (
        input  start, settle_cycles, expected, dut_out,
        output dut_in, busy, done, table_out, match
    );
`endif
endinterface

// File: rtl/truth_table_extractor.sv
// Sweeps a 3-input gate through rows 0..7, holding each row S cycles, and packs the sampled
// outputs into an 8-bit truth-table code. TT_EXTRACT_VOTE_EN: S+2 cycles/row, 3-sample majority.
module truth_table_extractor #(
    parameter int SETTLE_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    truth_table_extractor_if.slave   bus
);
    localparam int CW = SETTLE_W + 2;

    typedef enum logic {IDLE, SWEEP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] win_q, win_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    row_q, row_d;
    logic [6:0]    sh_q, sh_d;
    logic [7:0]    exp_q, exp_d;
    logic [7:0]    tbl_q, tbl_d;
    logic          match_q, match_d;
    logic          done_q, done_d;
    logic          row_bit;
    logic          row_end;
    logic          last_row;

`ifdef TT_EXTRACT_VOTE_EN
    logic [1:0]    vs_q, vs_d;
    logic          gacc_q, gacc_d;
    logic          glitch_q, glitch_d;
    logic          row_glitch;

    // vs_q[1] is the sample from edge W-2, vs_q[0] from W-1; dut_out is the one at edge W.
    always_comb begin
        row_bit    = (vs_q[1] & vs_q[0]) | (vs_q[1] & bus.dut_out) | (vs_q[0] & bus.dut_out);
        row_glitch = (vs_q[1] != vs_q[0]) || (vs_q[0] != bus.dut_out);
    end
    assign bus.glitch_seen = glitch_q;
`else
    assign row_bit = bus.dut_out;
`endif

    assign row_end  = (cnt_q == win_q);
    assign last_row = (row_q == 3'd7);

    assign bus.dut_in    = row_q;
    assign bus.busy      = (state_q == SWEEP);
    assign bus.done      = done_q;
    assign bus.table_out = tbl_q;
    assign bus.match     = match_q;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        sh_d    = sh_q;
        exp_d   = exp_q;
        tbl_d   = tbl_q;
        match_d = match_q;
        done_d  = 1'b0;
`ifdef TT_EXTRACT_VOTE_EN
        vs_d     = vs_q;
        gacc_d   = gacc_q;
        glitch_d = glitch_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SWEEP;
                    win_d   = (bus.settle_cycles == '0) ? CW'(1) : CW'(bus.settle_cycles);
`ifdef TT_EXTRACT_VOTE_EN
                    win_d    = win_d + CW'(2);
                    gacc_d   = 1'b0;
                    glitch_d = 1'b0;
`endif
                    // cnt counts edges inside the row window; the row ends when it reaches win.
                    cnt_d   = CW'(1);
                    row_d   = 3'd0;
                    sh_d    = '0;
                    exp_d   = bus.expected;
                end
            end
            SWEEP: begin
                cnt_d = cnt_q + CW'(1);
`ifdef TT_EXTRACT_VOTE_EN
                if (cnt_q == win_q - CW'(2) || cnt_q == win_q - CW'(1))
                    vs_d = {vs_q[0], bus.dut_out};
`endif
                if (row_end) begin
                    cnt_d = CW'(1);
                    sh_d  = {sh_q[5:0], row_bit};
`ifdef TT_EXTRACT_VOTE_EN
                    gacc_d = gacc_q | row_glitch;
`endif
                    if (last_row) begin
                        state_d = IDLE;
                        row_d   = 3'd0;
                        done_d  = 1'b1;
                        tbl_d   = {sh_q, row_bit};
                        match_d = ({sh_q, row_bit} == exp_q);
`ifdef TT_EXTRACT_VOTE_EN
                        glitch_d = gacc_q | row_glitch;
`endif
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= CW'(1);
            cnt_q   <= '0;
            row_q   <= 3'd0;
            sh_q    <= '0;
            exp_q   <= 8'h00;
            tbl_q   <= 8'h00;
            match_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef TT_EXTRACT_VOTE_EN
            vs_q     <= 2'b00;
            gacc_q   <= 1'b0;
            glitch_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            sh_q    <= sh_d;
            exp_q   <= exp_d;
            tbl_q   <= tbl_d;
            match_q <= match_d;
            done_q  <= done_d;
`ifdef TT_EXTRACT_VOTE_EN
            vs_q     <= vs_d;
            gacc_q   <= gacc_d;
            glitch_q <= glitch_d;
`endif
        end
    end
endmodule

// File: tb/tb_truth_table_extractor.sv
// Bench for truth_table_extractor: vector table, randomized sweeps vs a row-by-row model,
// plus hand sequences for re-start, reset mid-sweep, held start and (vote build) glitches.
module tb_truth_table_extractor;
    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] gate_code;
    logic glitch;
    int total = 0;
    int bad = 0;
    int repulse_at = 0;
    int glitch_at = 0;
    bit exp_glitch = 1'b0;

    always #5 clk = ~clk;

    truth_table_extractor_if #(.SETTLE_W(8)) bus ();
    truth_table_extractor #(.SETTLE_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Gate under test: output for row {in1,in2,in3} is bit (7-row) of its code.
    assign bus.dut_out = gate_code[3'd7 - bus.dut_in] ^ glitch;

    typedef struct {
        logic [7:0] settle;
        logic [7:0] gate;
        logic [7:0] expct;
        logic [7:0] tbl;
        bit         mt;
    } vec_t;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic int win(input logic [7:0] st);
        int s;
        s = (st == 8'd0) ? 1 : int'(st);
`ifdef TT_EXTRACT_VOTE_EN
        s = s + 2;
`endif
        return s;
    endfunction

    // Reference code: evaluate the gate on each row and place the result at bit (7-row).
    function automatic logic [7:0] ref_table(input logic [7:0] gate);
        logic [7:0] t;
        logic [7:0] g;
        t = 8'h00;
        g = gate;
        for (int r = 0; r < 8; r++)
            if (g[7-r]) t = t | (8'h80 >> r);
        return t;
    endfunction

    task automatic sweep(input string tag, input logic [7:0] st, input logic [7:0] gate,
                         input logic [7:0] ex, input logic [7:0] want_tbl, input bit want_mt);
        int w, lat, ndone, exp_row;
        bit trace_ok;
        w = win(st);
        lat = -1;
        ndone = 0;
        trace_ok = 1'b1;
        @(negedge clk);
        gate_code = gate;
        bus.settle_cycles = st;
        bus.expected = ex;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 8 * w + 4; k++) begin
            @(posedge clk);
            #1;
            exp_row = (k < 8 * w) ? (k / w) : 0;
            if (bus.dut_in != exp_row[2:0] || bus.busy != (k < 8 * w)) trace_ok = 1'b0;
            if (bus.done) begin
                ndone++;
                if (lat < 0) lat = k;
                if (bus.busy) trace_ok = 1'b0;
            end
            if (k == repulse_at) begin
                bus.start = 1'b1;
                bus.settle_cycles = 8'd7;
                bus.expected = ~ex;
            end else if (k == repulse_at + 1) begin
                bus.start = 1'b0;
            end
            glitch = (k == glitch_at);
        end
        glitch = 1'b0;
        chk({tag, ".latency"}, lat, 8 * w);
        chk({tag, ".ndone"}, ndone, 1);
        chk({tag, ".table"}, int'(bus.table_out), int'(want_tbl));
        chk({tag, ".match"}, int'(bus.match), int'(want_mt));
        chk({tag, ".trace"}, int'(trace_ok), 1);
`ifdef TT_EXTRACT_VOTE_EN
        chk({tag, ".glitch"}, int'(bus.glitch_seen), int'(exp_glitch));
`endif
    endtask

    initial begin
        vec_t vecs[6];
        logic [7:0] st, g, ex, t;
        int w, ndone, cyc;
        bit busy_done_ok;

        vecs[0] = '{settle: 8'd2,   gate: 8'h86, expct: 8'h86, tbl: 8'h86, mt: 1'b1};
        vecs[1] = '{settle: 8'd2,   gate: 8'h86, expct: 8'h87, tbl: 8'h86, mt: 1'b0};
        vecs[2] = '{settle: 8'd0,   gate: 8'hFF, expct: 8'hFF, tbl: 8'hFF, mt: 1'b1};
        vecs[3] = '{settle: 8'd1,   gate: 8'h00, expct: 8'h00, tbl: 8'h00, mt: 1'b1};
        vecs[4] = '{settle: 8'd3,   gate: 8'hA5, expct: 8'h5A, tbl: 8'hA5, mt: 1'b0};
        vecs[5] = '{settle: 8'd255, gate: 8'h3C, expct: 8'h3C, tbl: 8'h3C, mt: 1'b1};

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.settle_cycles = 8'd0;
        bus.expected = 8'h00;
        gate_code = 8'h00;
        glitch = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.dut_in", int'(bus.dut_in), 0);
        chk("rst.busy", int'(bus.busy), 0);
        chk("rst.done", int'(bus.done), 0);
        chk("rst.table", int'(bus.table_out), 0);
        chk("rst.match", int'(bus.match), 0);
`ifdef TT_EXTRACT_VOTE_EN
        chk("rst.glitch", int'(bus.glitch_seen), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            sweep($sformatf("vec%0d", i), vecs[i].settle, vecs[i].gate, vecs[i].expct,
                  vecs[i].tbl, vecs[i].mt);

        for (int i = 0; i < 20; i++) begin
            st = 8'($urandom_range(0, 4));
            g  = 8'($urandom);
            ex = ($urandom_range(0, 1) == 1) ? g : 8'($urandom);
            t  = ref_table(g);
            sweep($sformatf("rnd%0d", i), st, g, ex, t, t == ex);
        end

        // start re-pulsed mid-sweep with different settle/expected must be ignored.
        repulse_at = 5;
        sweep("repulse", 8'd2, 8'h86, 8'h86, 8'h86, 1'b1);
        repulse_at = 0;

        // Reset mid-sweep after a completed sweep left table_out non-zero.
        @(negedge clk);
        gate_code = 8'h86;
        bus.settle_cycles = 8'd2;
        bus.expected = 8'h86;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", int'(bus.busy), 0);
        chk("midrst.dut_in", int'(bus.dut_in), 0);
        chk("midrst.table", int'(bus.table_out), 0);
        chk("midrst.done", int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) ndone++;
        end
        chk("midrst.quiet", ndone, 0);
        sweep("postrst", 8'd2, 8'h86, 8'h86, 8'h86, 1'b1);

        // start held high: sweeps run back to back, done never overlaps busy.
        w = win(8'd1);
        ndone = 0;
        busy_done_ok = 1'b1;
        @(negedge clk);
        gate_code = 8'h86;
        bus.settle_cycles = 8'd1;
        bus.expected = 8'h86;
        bus.start = 1'b1;
        for (int k = 0; k <= 16 * w + 4; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                if (bus.busy) busy_done_ok = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("hold.ndone", ndone, 2);
        chk("hold.busy_done", int'(busy_done_ok), 1);
        chk("hold.table", int'(bus.table_out), 8'h86);
        cyc = 0;
        while (bus.busy && cyc < 8 * w + 8) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("hold.drain", int'(bus.busy), 0);
        repeat (2) @(posedge clk);

`ifdef TT_EXTRACT_VOTE_EN
        // One-cycle glitch on the middle sample of row 3 (window edges 10..12 for S=1).
        glitch_at = 10;
        exp_glitch = 1'b1;
        sweep("vote_glitch", 8'd1, 8'h86, 8'h86, 8'h86, 1'b1);
        glitch_at = 0;
        exp_glitch = 1'b0;
        sweep("vote_clean", 8'd1, 8'h86, 8'h86, 8'h86, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
